// File: rtl/wed_writeback_control_pkg.sv
// Shared types for the WED writeback path: PSL command/response lines, the WED layout and FSM states.
// WB_RETRY exists only when WED_WRITEBACK_RETRY_EN is defined.
package wed_writeback_control_pkg;

  localparam int unsigned CACHELINE_BITS = 1024;
  localparam int unsigned HALF_LINE_BITS = 512;
  localparam int unsigned WORD_BITS      = 64;
  localparam int unsigned WED_BITS       = 768;
  localparam int unsigned CU_ID_BITS     = 8;

  localparam logic [CU_ID_BITS-1:0] INVALID_ID   = 8'h00;
  localparam logic [CU_ID_BITS-1:0] WED_ID       = 8'hFE;
  localparam logic [1:0]            WB_MAX_RETRY = 2'd3;

  typedef enum logic [12:0] {
    INVALID    = 13'h0000,
    READ_CL_NA = 13'h0A00,
    WRITE_NA   = 13'h0D00
  } command_t;

  typedef enum logic [2:0] {
    STRICT = 3'b000,
    ABORT  = 3'b001,
    PAGE   = 3'b010,
    PREF   = 3'b011,
    SPEC   = 3'b111
  } trans_order_t;

  typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE, CMD_WED} cmd_type_t;

  typedef enum logic [2:0] {
    STRUCT_INVALID, INV_EDGE_ARRAY, EDGE_ARRAY, VERTEX_ARRAY, AUX_ARRAY
  } array_struct_t;

  typedef enum logic [7:0] {
    DONE    = 8'h00,
    AERROR  = 8'h01,
    DERROR  = 8'h03,
    NLOCK   = 8'h04,
    NRES    = 8'h05,
    FLUSHED = 8'h06,
    FAULT   = 8'h07,
    FAILED  = 8'h08,
    PAGED   = 8'h0A
  } psl_response_t;

  typedef enum logic [2:0] {
    WB_RESET,
    WB_IDLE,
    WB_REQ,
    WB_WAIT_RESP,
    WB_DONE
`ifdef WED_WRITEBACK_RETRY_EN
    , WB_RETRY
`endif
  } wb_state;

  typedef struct packed {
    logic [CU_ID_BITS-1:0] cu_id;
    cmd_type_t             cmd_type;
    array_struct_t         array_struct;
    logic [7:0]            real_size;
    logic [7:0]            tag;
    logic [31:0]           address_offest;
    logic [6:0]            cacheline_offest;
  } CommandTagLine;

  typedef struct packed {
    logic          valid;
    command_t      command;
    logic [0:63]   address;
    logic [0:11]   size;
    CommandTagLine cmd;
    trans_order_t  abt;
  } CommandBufferLine;

  typedef struct packed {
    logic                      valid;
    CommandTagLine             cmd;
    logic [0:HALF_LINE_BITS-1] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
    psl_response_t response;
    logic [7:0]    response_credits;
  } ResponseBufferLine;

  // Word k of the struct occupies cacheline bits [64k : 64k+63].
  typedef struct packed {
    logic [0:63] wed_flags;
    logic [0:63] num_vertices;
    logic [0:63] num_edges;
    logic [0:63] max_iterations;
    logic [0:63] vertex_in_degree;
    logic [0:63] vertex_out_degree;
    logic [0:63] vertex_edges_idx;
    logic [0:63] edges_array_src;
    logic [0:63] edges_array_dest;
    logic [0:63] edges_array_weight;
    logic [0:63] auxiliary1;
    logic [0:63] auxiliary2;
  } WED_request;

  typedef struct packed {
    logic       valid;
    WED_request wed;
  } WEDInterface;

  localparam CommandTagLine RESET_TAG = '{
    cu_id: INVALID_ID, cmd_type: CMD_INVALID, array_struct: STRUCT_INVALID,
    real_size: 8'd0, tag: 8'd0, address_offest: 32'd0, cacheline_offest: 7'd0};

  localparam CommandTagLine WB_TAG = '{
    cu_id: WED_ID, cmd_type: CMD_WED, array_struct: STRUCT_INVALID,
    real_size: 8'd32, tag: 8'd0, address_offest: 32'd0, cacheline_offest: 7'd0};

  localparam CommandBufferLine RESET_CMD = '{
    valid: 1'b0, command: INVALID, address: 64'd0, size: 12'd0, cmd: RESET_TAG, abt: STRICT};

  localparam ReadWriteDataLine RESET_DATA = '{valid: 1'b0, cmd: RESET_TAG, data: 512'd0};

  function automatic logic [0:CACHELINE_BITS-1] map_WED_to_DataArrays(input WED_request wed);
    return {wed, 256'h0};
  endfunction

  function automatic WED_request map_DataArrays_to_WED(input logic [0:CACHELINE_BITS-1] line);
    return WED_request'(line[0:WED_BITS-1]);
  endfunction

endpackage

// File: rtl/wed_writeback_control_if.sv
// Bus bundle between the WED writeback controller and the AFU command/response plumbing.
interface wed_writeback_control_if;
  import wed_writeback_control_pkg::*;

  logic              enabled_in;
  logic [0:63]       wed_address;
  WEDInterface       wed_request_in;
  logic              done_in;
  logic [0:63]       status_in;
  BufferStatus       command_buffer_status;
  ResponseBufferLine wed_response_in;
  CommandBufferLine  command_out;
  ReadWriteDataLine  write_data_0_out;
  ReadWriteDataLine  write_data_1_out;
  logic              wed_writeback_done_out;

  modport master (
    output enabled_in, wed_address, wed_request_in, done_in, status_in,
           command_buffer_status, wed_response_in,
    input  command_out, write_data_0_out, write_data_1_out, wed_writeback_done_out
  );

  modport slave (
    input  enabled_in, wed_address, wed_request_in, done_in, status_in,
           command_buffer_status, wed_response_in,
    output command_out, write_data_0_out, write_data_1_out, wed_writeback_done_out
  );
endinterface

// File: rtl/wed_writeback_control.sv
// Writes the WED cacheline (first word replaced by the completion status) back to host once all CUs finish.
// Define WED_WRITEBACK_RETRY_EN to reissue on non-DONE responses, up to WB_MAX_RETRY times.
module wed_writeback_control
  import wed_writeback_control_pkg::*;
(
  input logic                    clock,
  input logic                    rstn,
  wed_writeback_control_if.slave wb_if
);

  wb_state                   state_q, state_d;
  logic                      enabled_q;
  logic                      done_q, done_d;
  logic [0:CACHELINE_BITS-1] line_q, line_d;
  CommandBufferLine          command_q, command_d;
  ReadWriteDataLine          data0_q, data0_d;
  ReadWriteDataLine          data1_q, data1_d;
  logic                      issue_c;
  logic                      wed_resp_c;
`ifdef WED_WRITEBACK_RETRY_EN
  logic [1:0]                retry_q, retry_d;
`endif

  // Only responses tagged with our cu_id concern the writeback.
  assign wed_resp_c = wb_if.wed_response_in.valid && (wb_if.wed_response_in.cmd.cu_id == WED_ID);

  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    line_d    = line_q;
    done_d    = done_q;
    command_d = RESET_CMD;
    data0_d   = RESET_DATA;
    data1_d   = RESET_DATA;
`ifdef WED_WRITEBACK_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      WB_RESET: state_d = WB_IDLE;
      WB_IDLE: begin
        if (enabled_q && wb_if.wed_request_in.valid && wb_if.done_in && !done_q &&
            !wb_if.command_buffer_status.alfull) begin
          state_d        = WB_REQ;
          issue_c        = 1'b1;
          line_d         = map_WED_to_DataArrays(wb_if.wed_request_in.wed);
          line_d[0:63]   = wb_if.status_in;
`ifdef WED_WRITEBACK_RETRY_EN
          retry_d        = 2'd0;
`endif
        end
      end
      WB_REQ: state_d = WB_WAIT_RESP;
      WB_WAIT_RESP: begin
        if (wed_resp_c) begin
          state_d = WB_DONE;
`ifdef WED_WRITEBACK_RETRY_EN
          if (wb_if.wed_response_in.response != DONE && retry_q != WB_MAX_RETRY) begin
            state_d = WB_RETRY;
            retry_d = retry_q + 2'd1;
          end
`endif
        end
      end
      WB_DONE: state_d = WB_IDLE;
`ifdef WED_WRITEBACK_RETRY_EN
      WB_RETRY: begin
        if (!wb_if.command_buffer_status.alfull) begin
          state_d = WB_WAIT_RESP;
          issue_c = 1'b1;
        end
      end
`endif
      default: state_d = WB_RESET;
    endcase

    // Registered command/data lines are valid in the cycle after the issue decision.
    if (issue_c) begin
      command_d = '{valid: 1'b1, command: WRITE_NA, address: wb_if.wed_address,
                    size: 12'h080, cmd: WB_TAG, abt: STRICT};
      data0_d   = '{valid: 1'b1, cmd: WB_TAG, data: line_d[0:HALF_LINE_BITS-1]};
      data1_d   = '{valid: 1'b1, cmd: WB_TAG, data: line_d[HALF_LINE_BITS:CACHELINE_BITS-1]};
    end

    if (!enabled_q) done_d = 1'b0;
    if (state_d == WB_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= WB_RESET;
      enabled_q <= 1'b0;
      done_q    <= 1'b0;
      line_q    <= '0;
      command_q <= RESET_CMD;
      data0_q   <= RESET_DATA;
      data1_q   <= RESET_DATA;
`ifdef WED_WRITEBACK_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      enabled_q <= wb_if.enabled_in;
      done_q    <= done_d;
      line_q    <= line_d;
      command_q <= command_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
`ifdef WED_WRITEBACK_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign wb_if.command_out            = command_q;
  assign wb_if.write_data_0_out       = data0_q;
  assign wb_if.write_data_1_out       = data1_q;
  assign wb_if.wed_writeback_done_out = done_q;

  logic unused_bits;
  assign unused_bits = ^{wb_if.command_buffer_status, wb_if.wed_response_in};

endmodule
